mux_scan_ctrl: RTL

//   Sequencer that drives the S1/S0 select lines of the 4:1 gate-level mux and captures its output Y.
//   - Steps channels 0..3, holds each for DWELL cycles, then samples Y into a per-channel result bit.
//   - Reports a completed 4-channel frame.
//   - Sits on both sides of the mux: its select outputs feed the mux, and the mux's Y feeds back into it.

---
 rtl/mux_scan_pkg.sv | 18 +
 rtl/mux_scan_dwell_cnt.sv | 16 +
 rtl/mux_scan_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding, channel sizing and mask-walk helpers for the mux scan sequencer
package mux_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [SEL_W-1:0] first_ch(input logic [NUM_CH-1:0] m);
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (m[i]) first_ch = SEL_W'(i);
  endfunction
  function automatic logic has_next(input logic [NUM_CH-1:0] m, input logic [SEL_W-1:0] c);
    has_next = 1'b0;
    for (int i = 0; i < NUM_CH; i++) if (i > int'(c) && m[i]) has_next = 1'b1;
  endfunction
  function automatic logic [SEL_W-1:0] next_ch(input logic [NUM_CH-1:0] m, input logic [SEL_W-1:0] c);
    next_ch = c;
    for (int i = NUM_CH - 1; i >= 0; i--) if (i > int'(c) && m[i]) next_ch = SEL_W'(i);
  endfunction
endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// mux_scan_dwell_cnt: per-channel dwell counter, flags the last cycle of the dwell window
module mux_scan_dwell_cnt #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);
  logic [CNT_W-1:0] cnt;
  assign term = cnt == CNT_W'(DWELL - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clr || (en && term)) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: 4:1 mux select sequencer with per-channel Y capture; MUX_SCAN_MASK_EN adds a ch_mask channel-skip input
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              cont,
`ifdef MUX_SCAN_MASK_EN
  input  logic [NUM_CH-1:0] ch_mask,
`endif
  output logic              S0,
  output logic              S1,
  input  logic              Y,
  output logic [NUM_CH-1:0] ch_data,
  output logic              busy,
  output logic              frame_valid,
  output logic              done
);
  state_t state;
  logic [SEL_W-1:0] ch;
  logic [NUM_CH-1:0] mask_in, mask_q;
  logic term;
`ifdef MUX_SCAN_MASK_EN
  assign mask_in = ch_mask;
`else
  assign mask_in = '1;
`endif
  assign {S1, S0} = ch;
  mux_scan_dwell_cnt #(.DWELL(DWELL), .CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state != SCAN || stop),
    .en(state == SCAN),
    .term(term)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      ch_data <= '0;
      mask_q <= '1;
      busy <= 1'b0;
      frame_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        ch <= '0;
        busy <= 1'b0;
      end else
        case (state)
          IDLE:
            if (start) begin
              mask_q <= mask_in;
              ch <= first_ch(mask_in);
              state <= |mask_in ? SCAN : DONE;
              busy <= |mask_in;
              done <= ~|mask_in;
            end
          SCAN:
            if (term) begin
              ch_data[ch] <= Y;
              if (has_next(mask_q, ch))
                ch <= next_ch(mask_q, ch);
              else begin
                frame_valid <= 1'b1;
                ch <= cont ? first_ch(mask_q) : ch;
                state <= cont ? SCAN : DONE;
                busy <= cont;
                done <= ~cont;
              end
            end
          default: state <= IDLE;
        endcase
    end
endmodule
